line_buf_ctrl: RTL
==================

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 SHALL have parameter LINSIZE, default 16, meaning pixels per line.
REQ-002 SHALL have parameter NLINES, default 2, meaning number of line-buffer banks (window height minus 1).
REQ-003 SHALL have parameter FRMLINES, default 16, meaning lines per frame; legal range is FRMLINES > NLINES.
REQ-004 SHALL have parameter AW, default 4, meaning address width; legal range is 2^AW >= LINSIZE.
REQ-005 SHALL have parameter BW, default 1, meaning bank index width; legal range is 2^BW >= NLINES.
REQ-006 SHALL have parameter RD, default 3, meaning read latency in cycles; legal range is RD >= 1.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port en_in, input, 1 bit: input pixel valid this cycle.
REQ-010 SHALL have port flush, input, 1 bit: synchronous restart of the frame.
REQ-011 SHALL have port wr_addr, output, AW bits: write column address.
REQ-012 SHALL have port rd_addr, output, AW bits: read column address, applied to all banks.
REQ-013 SHALL have port web, output, NLINES bits: per-bank write enable, active low, at most one bit low.
REQ-014 SHALL have port rd_bank, output, BW bits: index of the oldest bank, i.e. the bank being overwritten.
REQ-015 SHALL have port rd_smp, output, 1 bit: read data valid, aligned to RD.
REQ-016 SHALL have port line_end, output, 1 bit: one-cycle pulse on the last pixel of each line.
REQ-017 SHALL have port frame_end, output, 1 bit: one-cycle pulse on the last pixel of each frame.

Function
REQ-018 SHALL hold internal counters col (0..LINSIZE-1), row (0..FRMLINES-1) and bank (0..NLINES-1), plus a state machine with states FILL and STREAM.
REQ-019 SHALL, at an edge with en_in=1 and flush=0, register wr_addr<=col, rd_addr<=col, web<=all ones except bit[bank]=0, and rd_bank<=bank.
REQ-020 SHALL, at the same edge, advance col to col+1, or to 0 when col==LINSIZE-1.
REQ-021 SHALL, on col wrap, set line_end<=1, advance bank to bank+1 (0 after NLINES-1), and advance row to row+1 (0 after FRMLINES-1).
REQ-022 SHALL, at an edge with en_in=0 and flush=0, set web<=all ones, hold wr_addr, rd_addr, col, row and bank, and set line_end<=0 and frame_end<=0.
REQ-023 SHALL move FILL->STREAM on the accepted pixel with row==NLINES-1 and col==LINSIZE-1.
REQ-024 SHALL move STREAM->FILL on the accepted pixel with row==FRMLINES-1 and col==LINSIZE-1; at that edge frame_end<=1 and bank<=0.
REQ-025 SHALL maintain rd_pipe, RD bits wide, shifting in (en_in && state==STREAM && !flush) every edge, with rd_smp=rd_pipe[RD-1]; a pixel presented in cycle c gives rd_smp=1 in cycle c+RD.
REQ-026 SHALL NOT assert rd_smp for any pixel accepted in FILL, including the pixel that causes FILL->STREAM.
REQ-027 SHALL give flush priority over en_in: at a flush edge, col, row, bank, wr_addr, rd_addr, rd_bank and rd_pipe are cleared to 0, web<=all ones, state<=FILL, and line_end and frame_end are cleared to 0.
REQ-028 SHALL produce all outputs from registers, with no combinational path from en_in or flush to any output.

Reset
REQ-029 SHALL, while rst=1 and independent of clk, force wr_addr=0, rd_addr=0, rd_bank=0, web=all ones, rd_smp=0, line_end=0, frame_end=0, col=0, row=0, bank=0, state=FILL and rd_pipe=0.
REQ-030 SHALL have the first pixel accepted after rst deasserts written to bank 0, column 0.

Verification
REQ-031 SHALL cover: defaults, 32 consecutive en_in cycles -> web=2'b10 for pixels 0-15 and 2'b01 for pixels 16-31, wr_addr 0..15 twice, line_end on pixels 15 and 31, rd_smp always 0, state STREAM after pixel 31.
REQ-032 SHALL cover: continuing en_in from pixel 32 (cycle c) -> rd_smp=1 from cycle c+3 onward, rd_addr=wr_addr, rd_bank=0 for pixels 32-47.
REQ-033 SHALL cover: en_in alternating 1/0 -> web all ones on every idle cycle, col advances only on active cycles, line_end after 16 active pixels.
REQ-034 SHALL cover: FRMLINES=4, 64 pixels -> frame_end one cycle on pixel 63, state FILL, bank=0, rd_smp drops 3 cycles after the last streaming pixel, next frame repeats scenario REQ-031.
REQ-035 SHALL cover: flush together with en_in at col=7 in STREAM -> next cycle web=all ones, wr_addr=0, rd_smp=0, next pixel written to bank 0, column 0.
REQ-036 SHALL cover: rst pulsed mid-line between clock edges -> all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/line_buf_if.sv
// Line-buffer controller bus.
// Groups the pixel handshake (en_in, flush) and the registered bank-control
// outputs (addresses, per-bank write enables, read bank, read-valid, pulses).
//   master : drives en_in/flush, receives the bank-control outputs
//   slave  : the controller side
interface line_buf_if #(
    parameter int NLINES = 2,
    parameter int AW     = 4,
    parameter int BW     = 1
);
    logic              en_in;
    logic              flush;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [NLINES-1:0] web;
    logic [BW-1:0]     rd_bank;
    logic              rd_smp;
    logic              line_end;
    logic              frame_end;

    modport master (
        output en_in, flush,
        input  wr_addr, rd_addr, web, rd_bank, rd_smp, line_end, frame_end
    );

    modport slave (
        input  en_in, flush,
        output wr_addr, rd_addr, web, rd_bank, rd_smp, line_end, frame_end
    );
endinterface

// File: rtl/line_buf_ctrl.sv
// Line-buffer controller for a sliding-window filter.
// Tracks column/row/bank of the incoming pixel stream, writes each pixel to
// the oldest of NLINES line banks and reads the same column from all banks.
// Read-valid (rd_smp) is only raised once NLINES lines are buffered, delayed
// by the RAM read latency RD.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : line_buf_if.slave (en_in, flush in; wr_addr, rd_addr, web,
//          rd_bank, rd_smp, line_end, frame_end out -- all registered)
module line_buf_ctrl #(
    parameter int LINSIZE  = 16,
    parameter int NLINES   = 2,
    parameter int FRMLINES = 16,
    parameter int AW       = 4,
    parameter int BW       = 1,
    parameter int RD       = 3
) (
    input  logic      clk,
    input  logic      rst,
    line_buf_if.slave bus
);
    localparam int RW = (FRMLINES > 1) ? $clog2(FRMLINES) : 1;
    localparam logic [AW-1:0] COL_LAST  = AW'(LINSIZE - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(FRMLINES - 1);
    localparam logic [RW-1:0] ROW_FILLD = RW'(NLINES - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(NLINES - 1);

    typedef enum logic {FILL, STREAM} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     col;
    logic [RW-1:0]     row;
    logic [BW-1:0]     bank;
    logic [RD-1:0]     rd_pipe;
    logic [AW-1:0]     wr_addr_q, rd_addr_q;
    logic [NLINES-1:0] web_q;
    logic [BW-1:0]     rd_bank_q;
    logic              line_end_q, frame_end_q;

    logic col_last, frame_last, stream_in;

    assign col_last   = (col == COL_LAST);
    assign frame_last = col_last && (row == ROW_LAST);
    // Only pixels accepted while streaming produce valid window reads.
    assign stream_in  = bus.en_in && !bus.flush && (state_q == STREAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FILL;
        end else if (bus.en_in && col_last) begin
            if (state_q == FILL && row == ROW_FILLD)
                state_d = STREAM;
            else if (state_q == STREAM && row == ROW_LAST)
                state_d = FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            bank        <= '0;
            rd_pipe     <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            web_q       <= '1;
            rd_bank_q   <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else if (bus.flush) begin
            col         <= '0;
            row         <= '0;
            bank        <= '0;
            rd_pipe     <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            web_q       <= '1;
            rd_bank_q   <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | RD'(stream_in);
            if (bus.en_in) begin
                wr_addr_q   <= col;
                rd_addr_q   <= col;
                web_q       <= ~(NLINES'(1) << bank);
                rd_bank_q   <= bank;
                line_end_q  <= col_last;
                frame_end_q <= frame_last;
                if (col_last) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    // A new frame always restarts at bank 0.
                    bank <= (frame_last || bank == BANK_LAST) ? '0 : bank + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                web_q       <= '1;
                line_end_q  <= 1'b0;
                frame_end_q <= 1'b0;
            end
        end
    end

    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.web       = web_q;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.rd_smp    = rd_pipe[RD-1];
    assign bus.line_end  = line_end_q;
    assign bus.frame_end = frame_end_q;
endmodule
